// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// opcode length classes and the default halt opcode.
package cpu_pkg;

  localparam int PC_W   = 9;
  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] HALT_OPCODE_DEF = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_ISSUE = 3'd4,
    ST_HALT  = 3'd5
  } fetch_state_t;

  // Length class is carried in opcode[7:6].
  typedef enum logic [1:0] {
    LCLS_ONE   = 2'b00,
    LCLS_TWO   = 2'b01,
    LCLS_THREE = 2'b10,
    LCLS_WIDE  = 2'b11
  } len_class_t;

  function automatic logic [1:0] class_len(input len_class_t cls);
    logic [1:0] len;
    case (cls)
      LCLS_ONE: len = 2'd1;
      LCLS_TWO: len = 2'd2;
      default:  len = 2'd3;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/instr_fetch_ilen_dec.sv
// Combinational instruction length decoder: maps an opcode to 1, 2 or 3 bytes.
module ilen_dec
  import cpu_pkg::*;
(
  input  logic [BYTE_W-1:0] opcode,
  output logic [1:0]        len
);

  always_comb begin
    len = class_len(len_class_t'(opcode[7:6]));
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: optional boot-time program load into program RAM,
// then an address / data / issue fetch loop with branch redirect and halt.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0]   RESET_PC    = 9'h000,
  parameter logic [BYTE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter bit                BOOT_LOAD   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_mode,
  input  logic              load_valid,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              load_done,
  output logic              load_ready,
  output logic              pram_wre,
  output logic [PC_W-1:0]   pram_addr,
  output logic [BYTE_W-1:0] pram_din,
  input  logic [BYTE_W-1:0] pram_dout0,
  input  logic [BYTE_W-1:0] pram_dout1,
  input  logic [BYTE_W-1:0] pram_dout2,
  input  logic              br_valid,
  input  logic [PC_W-1:0]   br_target,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [BYTE_W-1:0] ins_opcode,
  output logic [BYTE_W-1:0] ins_op1,
  output logic [BYTE_W-1:0] ins_op2,
  output logic [1:0]        ins_len,
  output logic [PC_W-1:0]   ins_pc,
  output logic              halted
);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] load_ptr;
  logic [1:0]      dec_len;
  logic            hs;
  logic            br_take;

  ilen_dec u_ilen_dec (
    .opcode (pram_dout0),
    .len    (dec_len)
  );

  assign hs      = ins_valid && ins_ready;
  // Redirects only matter while the fetch loop is running.
  assign br_take = br_valid &&
                   ((state == ST_ADDR) || (state == ST_DATA) || (state == ST_ISSUE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = (BOOT_LOAD && load_mode) ? ST_LOAD : ST_ADDR;
      ST_LOAD:  if (load_done) state_nxt = ST_ADDR;
      ST_ADDR:  state_nxt = br_take ? ST_ADDR : ST_DATA;
      ST_DATA:  state_nxt = br_take ? ST_ADDR : ST_ISSUE;
      ST_ISSUE: begin
        if (br_take) begin
          state_nxt = ST_ADDR;
        end else if (hs) begin
          state_nxt = (ins_opcode == HALT_OPCODE) ? ST_HALT : ST_ADDR;
        end
      end
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    pram_wre   = 1'b0;
    pram_addr  = '0;
    pram_din   = '0;
    halted     = 1'b0;
    case (state)
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          pram_wre  = 1'b1;
          pram_addr = load_ptr;
          pram_din  = load_data;
        end
      end
      ST_ADDR: pram_addr = pc;
      ST_HALT: halted    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      load_ptr   <= '0;
      ins_valid  <= 1'b0;
      ins_opcode <= '0;
      ins_op1    <= '0;
      ins_op2    <= '0;
      ins_len    <= '0;
      ins_pc     <= '0;
    end else begin
      if ((state == ST_LOAD) && load_valid) begin
        load_ptr <= load_ptr + 9'd1;
      end
      case (state)
        ST_IDLE: pc <= RESET_PC;
        ST_LOAD: if (load_done) pc <= RESET_PC;
        // RAM bytes for pc arrive this cycle; unused operand bytes are kept too.
        ST_DATA: begin
          if (!br_take) begin
            ins_opcode <= pram_dout0;
            ins_op1    <= pram_dout1;
            ins_op2    <= pram_dout2;
            ins_len    <= dec_len;
            ins_pc     <= pc;
            ins_valid  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (hs) begin
            ins_valid <= 1'b0;
            pc        <= pc + {7'd0, ins_len};
          end
        end
        default: ;
      endcase
      // A redirect overrides the sequential pc even when the handshake completes.
      if (br_take) begin
        pc        <= br_target;
        ins_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: program RAM model, behavioural
// fetch model checked every cycle, directed scenarios and random traffic.
module tb_instr_fetch;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_HALT = 3;

  logic       clk;
  logic       rst;
  logic       load_mode;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_done;
  logic       load_ready;
  logic       pram_wre;
  logic [8:0] pram_addr;
  logic [7:0] pram_din;
  logic [7:0] pram_dout0;
  logic [7:0] pram_dout1;
  logic [7:0] pram_dout2;
  logic       br_valid;
  logic [8:0] br_target;
  logic       ins_valid;
  logic       ins_ready;
  logic [7:0] ins_opcode;
  logic [7:0] ins_op1;
  logic [7:0] ins_op2;
  logic [1:0] ins_len;
  logic [8:0] ins_pc;
  logic       halted;

  int checks;
  int failures;

  instr_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .load_mode  (load_mode),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_done  (load_done),
    .load_ready (load_ready),
    .pram_wre   (pram_wre),
    .pram_addr  (pram_addr),
    .pram_din   (pram_din),
    .pram_dout0 (pram_dout0),
    .pram_dout1 (pram_dout1),
    .pram_dout2 (pram_dout2),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins_opcode (ins_opcode),
    .ins_op1    (ins_op1),
    .ins_op2    (ins_op2),
    .ins_len    (ins_len),
    .ins_pc     (ins_pc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program RAM: synchronous write, registered three-byte read.
  logic [7:0] ram [512];
  always @(posedge clk) begin
    if (pram_wre) ram[pram_addr] <= pram_din;
    pram_dout0 <= ram[pram_addr];
    pram_dout1 <= ram[pram_addr + 9'd1];
    pram_dout2 <= ram[pram_addr + 9'd2];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int ref_len(input logic [7:0] op);
    if (op < 8'h40) return 1;
    if (op < 8'h80) return 2;
    return 3;
  endfunction

  // Behavioural model state.
  logic [7:0] mem [512];
  int         phase;
  logic [8:0] m_pc;
  logic [8:0] m_ptr;
  int         m_age;
  bit         model_ok;
  int         m_hs;
  int         dut_hs;
  logic [8:0] dlog_pc [$];
  logic [7:0] dlog_op [$];
  logic [16:0] wlog [$];

  always @(negedge clk) begin
    logic [7:0] op;
    logic [8:0] a1;
    logic [8:0] a2;
    bit exp_v;
    bit hs;
    exp_v = model_ok && (phase == P_RUN) && (m_age >= 2);
    if (model_ok) begin
      chk("load_ready", int'(load_ready), int'(phase == P_LOAD));
      chk("halted", int'(halted), int'(phase == P_HALT));
      chk("pram_wre", int'(pram_wre), int'((phase == P_LOAD) && load_valid));
      chk("ins_valid", int'(ins_valid), int'(exp_v));
      if ((phase == P_LOAD) && load_valid) begin
        chk("load_addr", int'(pram_addr), int'(m_ptr));
        chk("load_din", int'(pram_din), int'(load_data));
      end
      if ((phase == P_RUN) && (m_age == 0)) chk("fetch_addr", int'(pram_addr), int'(m_pc));
      if (phase == P_IDLE) begin
        chk("idle_opcode", int'(ins_opcode), 0);
        chk("idle_op1", int'(ins_op1), 0);
        chk("idle_op2", int'(ins_op2), 0);
        chk("idle_len", int'(ins_len), 0);
        chk("idle_pc", int'(ins_pc), 0);
        chk("idle_addr", int'(pram_addr), 0);
        chk("idle_din", int'(pram_din), 0);
      end
      if (exp_v) begin
        op = mem[m_pc];
        a1 = m_pc + 9'd1;
        a2 = m_pc + 9'd2;
        chk("ins_pc", int'(ins_pc), int'(m_pc));
        chk("ins_opcode", int'(ins_opcode), int'(op));
        chk("ins_op1", int'(ins_op1), int'(mem[a1]));
        chk("ins_op2", int'(ins_op2), int'(mem[a2]));
        chk("ins_len", int'(ins_len), ref_len(op));
      end
    end
    if (ins_valid && ins_ready) begin
      dut_hs++;
      dlog_pc.push_back(ins_pc);
      dlog_op.push_back(ins_opcode);
    end
    if (pram_wre) wlog.push_back({pram_addr, pram_din});
    if (model_ok && (phase == P_LOAD) && load_valid) begin
      mem[m_ptr] = load_data;
      m_ptr = m_ptr + 9'd1;
    end
    if (rst) begin
      model_ok = 1'b1;
      phase = P_IDLE;
      m_pc = 9'h000;
      m_ptr = 9'h000;
      m_age = 0;
    end else if (model_ok) begin
      case (phase)
        P_IDLE: begin
          phase = load_mode ? P_LOAD : P_RUN;
          m_pc = 9'h000;
          m_age = 0;
        end
        P_LOAD: if (load_done) begin
          phase = P_RUN;
          m_pc = 9'h000;
          m_age = 0;
        end
        P_RUN: begin
          hs = exp_v && ins_ready;
          if (hs) m_hs++;
          if (br_valid) begin
            m_pc = br_target;
            m_age = 0;
          end else if (hs) begin
            op = mem[m_pc];
            m_pc = m_pc + 9'(ref_len(op));
            m_age = 0;
            if (op == 8'hFF) phase = P_HALT;
          end else if (m_age < 2) begin
            m_age++;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit mode);
    step();
    rst = 1'b1;
    load_mode = mode;
    load_valid = 1'b0;
    load_done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!load_ready && n < 10) begin
      step();
      n++;
    end
    chk("wait_load_ready", int'(load_ready), 1);
  endtask

  task automatic load_bytes(input logic [7:0] b[$], input bit done_with_last);
    int n;
    wait_ready(n);
    for (int i = 0; i < b.size(); i++) begin
      load_valid = 1'b1;
      load_data = b[i];
      load_done = done_with_last && (i == b.size() - 1);
      step();
    end
    if (!done_with_last) begin
      load_valid = 1'b0;
      load_done = 1'b1;
      step();
    end
    load_valid = 1'b0;
    load_done = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    int n;
    n = 0;
    while (!ins_valid && n < max) begin
      step();
      n++;
    end
    chk("wait_ins_valid", int'(ins_valid), 1);
  endtask

  initial begin
    logic [7:0] prog [$];
    logic [7:0] h_op;
    logic [8:0] h_pc;
    int n;
    int mark;
    checks = 0;
    failures = 0;
    model_ok = 1'b0;
    m_hs = 0;
    dut_hs = 0;
    for (int i = 0; i < 512; i++) begin
      ram[i] = 8'h00;
      mem[i] = 8'h00;
    end
    rst = 1'b0;
    load_mode = 1'b0;
    load_valid = 1'b0;
    load_data = 8'h00;
    load_done = 1'b0;
    br_valid = 1'b0;
    br_target = 9'h000;
    ins_ready = 1'b0;

    // Four-byte program, done with last byte, decoder always ready.
    ins_ready = 1'b1;
    do_reset(1'b1);
    wait_ready(n);
    chk("load_ready_latency", n, 1);
    wlog.delete();
    dlog_pc.delete();
    dlog_op.delete();
    prog = '{8'h01, 8'h40, 8'h22, 8'hFF};
    load_bytes(prog, 1'b1);
    chk("wlog_size", wlog.size(), 4);
    chk("wlog0", int'(wlog[0]), int'({9'd0, 8'h01}));
    chk("wlog3", int'(wlog[3]), int'({9'd3, 8'hFF}));
    n = 0;
    while (!halted && n < 40) begin
      step();
      n++;
    end
    chk("halt_reached", int'(halted), 1);
    chk("issue_count", dlog_pc.size(), 3);
    chk("issue0_pc", int'(dlog_pc[0]), 0);
    chk("issue0_op", int'(dlog_op[0]), 8'h01);
    chk("issue1_pc", int'(dlog_pc[1]), 1);
    chk("issue2_pc", int'(dlog_pc[2]), 3);
    chk("issue2_op", int'(dlog_op[2]), 8'hFF);
    br_valid = 1'b1;
    br_target = 9'h010;
    step();
    br_valid = 1'b0;
    step();
    chk("halt_holds", int'(halted), 1);

    // Back-pressure: stall five cycles in ISSUE, no load.
    ins_ready = 1'b0;
    do_reset(1'b0);
    wait_valid(10);
    h_op = ins_opcode;
    h_pc = ins_pc;
    chk("stall_pc0", int'(ins_pc), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", int'(ins_valid), 1);
      chk("stall_opcode", int'(ins_opcode), int'(h_op));
      chk("stall_pc", int'(ins_pc), int'(h_pc));
    end
    ins_ready = 1'b1;
    step();
    wait_valid(10);
    chk("after_stall_pc", int'(ins_pc), 1);

    // 513-byte load wraps the pointer; branches ignored during load.
    prog.delete();
    for (int i = 0; i < 513; i++) prog.push_back(8'($urandom_range(0, 254)));
    prog[1] = 8'h5A;
    prog[511] = 8'h80;
    prog[512] = 8'h3C;
    br_valid = 1'b1;
    br_target = 9'h055;
    do_reset(1'b1);
    load_bytes(prog, 1'b0);
    br_valid = 1'b0;
    wait_valid(10);
    chk("post_load_pc", int'(ins_pc), 0);
    chk("wrap_overwrite", int'(ins_opcode), 8'h3C);
    step();
    step();
    br_valid = 1'b1;
    br_target = 9'h1F0;
    mark = dlog_pc.size();
    step();
    br_valid = 1'b0;
    wait_valid(10);
    chk("br_data_pc", int'(ins_pc), 9'h1F0);
    chk("br_data_no_issue", dlog_pc.size(), mark);
    br_valid = 1'b1;
    br_target = 9'h1FF;
    step();
    br_valid = 1'b0;
    chk("br_hs_consumed", int'(dlog_pc[mark]), 9'h1F0);
    wait_valid(10);
    chk("wrap_pc", int'(ins_pc), 9'h1FF);
    chk("wrap_opcode", int'(ins_opcode), 8'h80);
    chk("wrap_op1", int'(ins_op1), 8'h3C);
    chk("wrap_op2", int'(ins_op2), 8'h5A);
    chk("wrap_len", int'(ins_len), 3);
    step();
    wait_valid(10);
    chk("wrap_next_pc", int'(ins_pc), 9'h002);

    // Random back-pressure and redirects.
    for (int i = 0; i < 2500; i++) begin
      step();
      ins_ready = ($urandom_range(0, 9) < 7);
      br_valid = ($urandom_range(0, 19) == 0);
      br_target = 9'($urandom_range(0, 511));
    end
    br_valid = 1'b0;

    // Reset during load, then during issue.
    ins_ready = 1'b0;
    do_reset(1'b1);
    wait_ready(n);
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data = 8'($urandom_range(0, 254));
      step();
    end
    rst = 1'b1;
    step();
    chk("rst_load_wre", int'(pram_wre), 0);
    chk("rst_load_ready", int'(load_ready), 0);
    rst = 1'b0;
    load_mode = 1'b0;
    step();
    chk("rst_load_no_write", int'(pram_wre), 0);
    load_valid = 1'b0;
    wait_valid(10);
    rst = 1'b1;
    step();
    chk("rst_issue_valid", int'(ins_valid), 0);
    chk("rst_issue_opcode", int'(ins_opcode), 0);
    chk("rst_issue_pc", int'(ins_pc), 0);
    rst = 1'b0;
    step();
    step();
    chk("handshake_total", dut_hs, m_hs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RESET_PC, 9'h000, PC loaded on reset and on load completion
- HALT_OPCODE, 8'hFF, opcode that stops fetching
- BOOT_LOAD, 1, 1 enables the program-load path; 0 ignores load_mode
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset: synchronous, active-high
- load_mode  in  1  request program load after reset
- load_valid  in  1  load byte present
- load_data  in  8  byte to write to program RAM
- load_done  in  1  end of load stream
- load_ready  out  1  block accepts load bytes
- pram_wre  out  1  program RAM write enable
- pram_addr  out  9  program RAM address
- pram_din  out  8  program RAM write data
- pram_dout0/1/2  in  8 each  RAM bytes at addr, addr+1, addr+2, valid one cycle after addr presented with wre=0
- br_valid  in  1  branch redirect
- br_target  in  9  redirect PC
- ins_valid  out  1  instruction available
- ins_ready  in  1  decoder accepts instruction
- ins_opcode / ins_op1 / ins_op2  out  8 each  instruction bytes
- ins_len  out  2  instruction length in bytes (1..3)
- ins_pc  out  9  address of ins_opcode
- halted  out  1  HALT state reached

Function
REQ-003 States SHALL be IDLE, LOAD, ADDR, DATA, ISSUE, HALT.
REQ-004 IDLE SHALL go to LOAD if BOOT_LOAD=1 and load_mode=1, otherwise to ADDR with pc=RESET_PC.
REQ-005 In LOAD, load_ready SHALL be 1; each load_valid cycle SHALL drive pram_wre=1, pram_addr=load_ptr, pram_din=load_data, then load_ptr increments mod 512 (511 wraps to 0).
REQ-006 load_done SHALL move LOAD to ADDR with pc=RESET_PC; a load_valid in the same cycle SHALL still be written.
REQ-007 In ADDR, pram_wre=0 and pram_addr=pc; next state DATA.
REQ-008 In DATA, pram_dout0/1/2 SHALL be registered into ins_opcode/op1/op2, ins_pc<=pc, ins_len decoded, ins_valid<=1; next state ISSUE.
REQ-009 Length SHALL be: opcode[7:6]=00 -> 1, 01 -> 2, 10 or 11 -> 3.
REQ-010 Unused operand bytes SHALL still be registered as read; the decoder ignores them by ins_len.
REQ-011 In ISSUE, ins_* SHALL stay stable while ins_valid=1 and ins_ready=0.
REQ-012 On ins_valid && ins_ready, ins_valid SHALL clear and pc<=pc+ins_len mod 512; next state ADDR, or HALT if ins_opcode=HALT_OPCODE.
REQ-013 The HALT_OPCODE instruction SHALL itself be issued to the decoder before halting.
REQ-014 br_valid in ADDR, DATA or ISSUE SHALL set pc<=br_target, clear ins_valid, go to ADDR; an instruction handshaking in the same cycle counts as consumed, but br_target wins over pc+ins_len.
REQ-015 br_valid SHALL be ignored in IDLE, LOAD and HALT.
REQ-016 HALT SHALL hold halted=1 and ins_valid=0 and exit only on rst.
REQ-017 Steady-state throughput SHALL be one instruction per 3 cycles with ins_ready held high.

Reset
REQ-018 rst SHALL set state=IDLE, pc=RESET_PC, load_ptr=0, ins_valid=0, ins_opcode/op1/op2=0, ins_len=0, ins_pc=0, halted=0, load_ready=0, pram_wre=0, pram_addr=0, pram_din=0.
REQ-019 rst mid-load or mid-fetch SHALL abandon the operation with no further RAM write after the reset cycle.

Structure
REQ-020 cpu_pkg SHALL hold the state encoding, opcode[7:6] length classes, and the HALT opcode default.
REQ-021 One sub-module, ilen_dec (opcode in, 2-bit length out, combinational), SHALL implement REQ-009.

Verification
REQ-022 Load 8'h01,8'h40,8'h22,8'hFF then load_done -> writes at addr 0..3, first fetch ins_pc=0, opcode=01, len=1.
REQ-023 ins_ready=1 continuously -> ins_pc sequence 0,1,3 (len 1,2); opcode FF at pc 3 issued, then halted=1.
REQ-024 ins_ready=0 for 5 cycles in ISSUE -> ins_* unchanged; pc advances only after acceptance.
REQ-025 br_valid with br_target=9'h1F0 during DATA -> no issue of pending instruction; next ins_pc=9'h1F0.
REQ-026 3-byte opcode 8'h80 at pc=9'h1FF, plus 513 load bytes -> ins_op1/op2 from addrs 0/1, next pc=9'h002; load byte 513 overwrites addr 0.
REQ-027 rst during LOAD and during ISSUE -> all outputs at reset values next cycle; state IDLE.
